// File: rtl/trivium_stream_if.sv
// Keystream output channel for trivium_stream: valid/ready word handshake.
interface trivium_stream_if #(
  parameter int W = 8
);
  logic [W-1:0] ks_data;
  logic         ks_valid;
  logic         ks_ready;

  modport master (output ks_data, output ks_valid, input ks_ready);
  modport slave  (input ks_data, input ks_valid, output ks_ready);
endinterface

// File: rtl/trivium_stream.sv
// Trivium keystream generator, W bits per clock, bounded run with valid/ready output.
// Optional build macro TRIVIUM_XOR_EN adds pt_data and emits pt_data ^ keystream.
module trivium_stream #(
  parameter int W           = 8,
  parameter int INIT_ROUNDS = 1152,
  parameter int LEN_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [79:0]      key,
  input  logic [79:0]      iv,
  input  logic [LEN_W-1:0] len,
  input  logic             start,
  output logic             busy,
  output logic             done,
`ifdef TRIVIUM_XOR_EN
  input  logic [W-1:0]     pt_data,
`endif
  trivium_stream_if.master ks
);

  localparam int WARM_CYC = INIT_ROUNDS / W;
  localparam int WC_W     = $clog2(WARM_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Key/IV bytes enter the register in reverse byte order.
  function automatic logic [79:0] byte_rev(input logic [79:0] x);
    logic [79:0] r;
    r = 80'd0;
    for (int i = 0; i < 10; i++) begin
      r[8*i +: 8] = x[79-8*i -: 8];
    end
    return r;
  endfunction

  // W chained bit-steps: returns {keystream word, advanced state}, earliest bit in the MSB.
  function automatic logic [W+287:0] trivium_adv(input logic [287:0] s_in);
    logic [287:0] s;
    logic [W-1:0] z;
    logic         t1;
    logic         t2;
    logic         t3;
    s = s_in;
    z = {W{1'b0}};
    for (int k = 0; k < W; k++) begin
      t1 = s[65] ^ s[92];
      t2 = s[161] ^ s[176];
      t3 = s[242] ^ s[287];
      z[W-1-k] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[90] & s[91]) ^ s[170];
      t2 = t2 ^ (s[174] & s[175]) ^ s[263];
      t3 = t3 ^ (s[285] & s[286]) ^ s[68];
      s = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
    end
    return {z, s};
  endfunction

  state_t           state_r;
  state_t           state_nx_s;
  logic [287:0]     s_r;
  logic [287:0]     s_adv_s;
  logic [W-1:0]     z_s;
  logic [W-1:0]     word_s;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] word_cnt_r;
  logic [WC_W-1:0]  warm_cnt_r;
  logic             busy_r;
  logic             done_r;
  logic             valid_r;
  logic             load_s;
  logic             adv_s;
  logic             hs_s;
  logic             warm_last_s;
  logic             word_last_s;

  assign {z_s, s_adv_s} = trivium_adv(s_r);
  assign hs_s           = valid_r & ks.ks_ready;
  assign warm_last_s    = (warm_cnt_r == WC_W'(WARM_CYC - 1));
  // Compare against len-1 so len = all-ones finishes without the counter wrapping.
  assign word_last_s    = (word_cnt_r == (len_r - LEN_W'(1)));

`ifdef TRIVIUM_XOR_EN
  assign word_s = z_s ^ pt_data;
`else
  assign word_s = z_s;
`endif

  assign ks.ks_data  = valid_r ? word_s : {W{1'b0}};
  assign ks.ks_valid = valid_r;
  assign busy        = busy_r;
  assign done        = done_r;

  // Next-state decode and datapath enables.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    adv_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s     = 1'b1;
          state_nx_s = ST_WARM;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WARM: begin
        adv_s = 1'b1;
        if (warm_last_s) begin
          if (len_r == {LEN_W{1'b0}}) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_RUN;
          end
        end else begin
          state_nx_s = ST_WARM;
        end
      end
      ST_RUN: begin
        if (hs_s) begin
          adv_s = 1'b1;
          if (word_last_s) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_RUN;
          end
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Cipher state, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_r        <= 288'd0;
      len_r      <= {LEN_W{1'b0}};
      word_cnt_r <= {LEN_W{1'b0}};
      warm_cnt_r <= {WC_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      busy_r  <= (state_nx_s != ST_IDLE);
      done_r  <= (state_nx_s == ST_DONE);
      valid_r <= (state_nx_s == ST_RUN);
      if (load_s) begin
        s_r        <= {3'b111, 112'd0, byte_rev(iv), 13'd0, byte_rev(key)};
        len_r      <= len;
        word_cnt_r <= {LEN_W{1'b0}};
        warm_cnt_r <= {WC_W{1'b0}};
      end else begin
        if (adv_s) begin
          s_r <= s_adv_s;
        end
        if (state_r == ST_WARM) begin
          warm_cnt_r <= warm_cnt_r + WC_W'(1);
        end
        if ((state_r == ST_RUN) && hs_s) begin
          word_cnt_r <= word_cnt_r + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_trivium_stream.sv
// Randomized self-checking bench for trivium_stream against a bit-serial Trivium model.
module tb_trivium_stream;

  localparam int W        = 8;
  localparam int INIT     = 1152;
  localparam int WARM_CYC = INIT / W;
`ifdef TRIVIUM_XOR_EN
  localparam logic [7:0] PT = 8'hFF;
`else
  localparam logic [7:0] PT = 8'h00;
`endif

  logic        clk;
  logic        reset;
  logic [79:0] key;
  logic [79:0] iv;
  logic [15:0] len;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  pt_data;

  trivium_stream_if #(.W(W)) ks_if ();

  trivium_stream #(.W(W), .INIT_ROUNDS(INIT), .LEN_W(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .key    (key),
    .iv     (iv),
    .len    (len),
    .start  (start),
    .busy   (busy),
    .done   (done),
`ifdef TRIVIUM_XOR_EN
    .pt_data(pt_data),
`endif
    .ks     (ks_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] rand80();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[79:0];
  endfunction

  // Reference: Trivium as a 288-cell shift register, cells numbered 1..288.
  bit         m_s [1:288];
  logic [7:0] exp_q[$];

  task automatic m_step(output bit z);
    bit t1, t2, t3;
    t1 = m_s[66] ^ m_s[93];
    t2 = m_s[162] ^ m_s[177];
    t3 = m_s[243] ^ m_s[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (m_s[91] & m_s[92]) ^ m_s[171];
    t2 = t2 ^ (m_s[175] & m_s[176]) ^ m_s[264];
    t3 = t3 ^ (m_s[286] & m_s[287]) ^ m_s[69];
    for (int i = 288; i > 1; i--) m_s[i] = m_s[i-1];
    m_s[1]   = t3;
    m_s[94]  = t1;
    m_s[178] = t2;
  endtask

  task automatic model_gen(input logic [79:0] k, input logic [79:0] v, input int n);
    bit         z;
    logic [7:0] w;
    exp_q.delete();
    for (int i = 1; i <= 288; i++) m_s[i] = 1'b0;
    // Cell i+1 takes bit (i%8) of byte (9 - i/8) of the key / IV.
    for (int i = 0; i < 80; i++) begin
      m_s[i+1]  = k[8*(9 - i/8) + i%8];
      m_s[94+i] = v[8*(9 - i/8) + i%8];
    end
    m_s[286] = 1'b1;
    m_s[287] = 1'b1;
    m_s[288] = 1'b1;
    repeat (INIT) m_step(z);
    for (int j = 0; j < n; j++) begin
      for (int b = 7; b >= 0; b--) begin
        m_step(z);
        w[b] = z;
      end
      exp_q.push_back(w ^ PT);
    end
  endtask

  // One complete run; rmode 0 = always ready, 1 = ready pattern 1,0,0, 2 = random ready.
  task automatic run_check(input string nm, input logic [79:0] k, input logic [79:0] v,
                           input int n, input int rmode, input bit collide);
    int         cyc;
    int         hs;
    int         last_hs;
    int         done_cyc;
    bit         prev_stall;
    logic [7:0] prev_data;
    bit         rdy;
    model_gen(k, v, n);
    key = k; iv = v; len = 16'(n); start = 1'b1; ks_if.ks_ready = 1'b1;
    tick();
    start = 1'b0; key = rand80(); iv = rand80(); len = 16'($urandom);
    chk({nm, "_busy_e0"}, busy, 1);
    cyc = 0;
    while (!ks_if.ks_valid && !done && cyc < WARM_CYC + 8) begin
      start = collide && (cyc == 20);
      tick();
      cyc++;
    end
    start = 1'b0;
    chk({nm, "_warm_lat"}, cyc, WARM_CYC);
    if (n == 0) begin
      chk({nm, "_zero_done"}, done, 1);
      chk({nm, "_zero_valid"}, ks_if.ks_valid, 0);
    end else begin
      hs = 0; last_hs = 0; done_cyc = -1; prev_stall = 1'b0; prev_data = 8'h00;
      while (cyc < WARM_CYC + 4*n + 16) begin
        if (done) begin
          done_cyc = cyc;
          break;
        end
        if (prev_stall) chk({nm, "_stall_hold"}, {ks_if.ks_valid, ks_if.ks_data}, {1'b1, prev_data});
        case (rmode)
          0:       rdy = 1'b1;
          1:       rdy = ((cyc - WARM_CYC) % 3 == 0);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        ks_if.ks_ready = rdy;
        start = collide && (cyc == WARM_CYC + 1);
        if (ks_if.ks_valid && rdy) begin
          if (hs < n) chk({nm, "_word"}, ks_if.ks_data, exp_q[hs]);
          hs++;
          last_hs = cyc;
        end
        prev_stall = ks_if.ks_valid && !rdy;
        prev_data  = ks_if.ks_data;
        tick();
        cyc++;
      end
      start = 1'b0;
      ks_if.ks_ready = 1'b1;
      chk({nm, "_handshakes"}, hs, n);
      chk({nm, "_done_after_last"}, done_cyc, last_hs + 1);
      if (rmode == 0) chk({nm, "_done_lat"}, done_cyc, WARM_CYC + n);
    end
    tick();
    chk({nm, "_done_pulse"}, done, 0);
    chk({nm, "_busy_end"}, busy, 0);
  endtask

  initial begin
    logic [79:0] k;
    int          cyc;
    pt_data = PT;
    reset = 1'b1; start = 1'b0; key = 80'd0; iv = 80'd0; len = 16'd0;
    ks_if.ks_ready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", ks_if.ks_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_data", ks_if.ks_data, 0);
    reset = 1'b0;
    tick();

    run_check("golden", 80'd0, 80'd0, 8, 0, 1'b0);
    run_check("bp", 80'h0123456789ABCDEF0011, 80'hFEDCBA98765432100022, 4, 1, 1'b0);
    run_check("bp_ref", 80'h0123456789ABCDEF0011, 80'hFEDCBA98765432100022, 4, 0, 1'b0);
    run_check("zero", rand80(), rand80(), 0, 0, 1'b0);
    run_check("collide", rand80(), rand80(), 5, 0, 1'b1);
    for (int r = 0; r < 3; r++) begin
      run_check("rand", rand80(), rand80(), $urandom_range(1, 6), 2, 1'b0);
    end

    // Reset in the middle of a run, then a fresh run with the same key/IV.
    k = rand80();
    key = k; iv = 80'd0; len = 16'd20; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!ks_if.ks_valid && cyc < WARM_CYC + 8) begin
      tick();
      cyc++;
    end
    chk("midrun_valid", ks_if.ks_valid, 1);
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", ks_if.ks_valid, 0);
    chk("midrst_done", done, 0);
    chk("midrst_data", ks_if.ks_data, 0);
    reset = 1'b0;
    tick();
    chk("midrst_idle_busy", busy, 0);
    run_check("post_rst", k, 80'd0, 3, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
